// File: rtl/tt_logic_pkg.sv
// Shared definitions for the logic-unit arbiter: op encodings, FSM states, sizes.
package tt_logic_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned TMO_W   = 4;

    localparam logic [1:0] OpXor  = 2'b00;
    localparam logic [1:0] OpAnd  = 2'b01;
    localparam logic [1:0] OpOr   = 2'b10;
    localparam logic [1:0] OpXnor = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StEval,
        StHold
    } state_e;

    function automatic logic logic_op(input logic [1:0] op, input logic a, input logic b);
        logic r;
        unique case (op)
            OpXor:   r = a ^ b;
            OpAnd:   r = a & b;
            OpOr:    r = a | b;
            default: r = ~(a ^ b);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// Combinational 4-way arbiter: round-robin from ptr_i, or fixed lowest-index priority.
module rr_arbiter_4
    import tt_logic_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [1:0]         ptr_i,
    input  logic               mode_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [1:0]         idx_o
);

    logic       found;
    logic [1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // 2-bit add wraps 3 -> 0 naturally
            cand = mode_i ? 2'(i) : ptr_i + 2'(i);
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                idx_o          = cand;
                grant_o[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tt_um_logic_arbiter.sv
// Four requesters share one 2-input logic unit; IDLE -> EVAL -> HOLD per transaction.
module tt_um_logic_arbiter
    import tt_logic_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [TMO_W-1:0] TmoLast = TMO_W'(TIMEOUT - 1);

    logic [NUM_REQ-1:0] req;
    logic               mode, clear;

    assign req   = ui_in[3:0];
    assign mode  = ui_in[6];
    assign clear = ui_in[7];

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [1:0]         idx_q, idx_d;
    logic [1:0]         op_q, op_d;
    logic               a_q, a_d, b_q, b_d;
    logic               result_q, result_d;
    logic               valid_q, valid_d;
    logic [1:0]         count_q, count_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [1:0]         arb_idx;

    rr_arbiter_4 u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .mode_i  (mode),
        .grant_o (arb_grant),
        .idx_o   (arb_idx)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        idx_d    = idx_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        valid_d  = valid_q;
        count_d  = count_q;
        ptr_d    = ptr_q;
        tmo_d    = tmo_q;

        unique case (state_q)
            StIdle: begin
                if (ena && |req) begin
                    state_d = StEval;
                    grant_d = arb_grant;
                    idx_d   = arb_idx;
                    op_d    = ui_in[5:4];
                    a_d     = uio_in[{arb_idx, 1'b0}];
                    b_d     = uio_in[{arb_idx, 1'b1}];
                end
            end
            StEval: begin
                state_d  = StHold;
                result_d = logic_op(op_q, a_q, b_q);
                valid_d  = 1'b1;
                tmo_d    = '0;
            end
            StHold: begin
                // Ack is checked first so a coincident timeout still counts
                if (!req[idx_q] || tmo_q >= TmoLast) begin
                    state_d  = StIdle;
                    grant_d  = '0;
                    valid_d  = 1'b0;
                    result_d = 1'b0;
                    tmo_d    = '0;
                    ptr_d    = idx_q + 2'd1;
                    if (!req[idx_q]) begin
                        count_d = count_q + 2'd1;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (!ena) begin
            state_d  = StIdle;
            grant_d  = '0;
            valid_d  = 1'b0;
            result_d = 1'b0;
            tmo_d    = '0;
            count_d  = count_q;
            ptr_d    = ptr_q;
        end

        if (clear) begin
            count_d = '0;
            ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            idx_q    <= '0;
            op_q     <= '0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            result_q <= 1'b0;
            valid_q  <= 1'b0;
            count_q  <= '0;
            ptr_q    <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            idx_q    <= idx_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
            ptr_q    <= ptr_d;
            tmo_q    <= tmo_d;
        end
    end

    assign uo_out  = {count_q, valid_q, result_q, grant_q};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_logic_arbiter.sv
// Directed bench for tt_um_logic_arbiter (TIMEOUT=3): vector table plus corner sequences.
module tb_tt_um_logic_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [3:0] req = '0;
    logic [1:0] op = '0;
    logic       mode = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] uio = '0;
    logic [7:0] ui_in;
    logic [7:0] uo_out, uio_out, uio_oe;

    int checks = 0;
    int failures = 0;
    logic [1:0] exp_cnt = '0;

    assign ui_in = {clr, mode, op, req};

    tt_um_logic_arbiter #(.TIMEOUT(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [1:0] op;
        logic [7:0] uio;
        logic [3:0] grant;
        logic       res;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // fixed mode, pointer irrelevant: lowest set index wins
        vecs[0] = '{req: 4'b0001, op: 2'b00, uio: 8'b0000_0001, grant: 4'b0001, res: 1'b1};
        vecs[1] = '{req: 4'b0010, op: 2'b01, uio: 8'b0000_1100, grant: 4'b0010, res: 1'b1};
        vecs[2] = '{req: 4'b0100, op: 2'b10, uio: 8'b1100_0011, grant: 4'b0100, res: 1'b0};
        vecs[3] = '{req: 4'b1000, op: 2'b11, uio: 8'b0100_0000, grant: 4'b1000, res: 1'b0};
        vecs[4] = '{req: 4'b0110, op: 2'b00, uio: 8'b0000_0100, grant: 4'b0010, res: 1'b1};
        vecs[5] = '{req: 4'b1100, op: 2'b11, uio: 8'b0011_0000, grant: 4'b0100, res: 1'b1};
        vecs[6] = '{req: 4'b1010, op: 2'b01, uio: 8'b1100_0100, grant: 4'b0010, res: 1'b0};

        #3;
        chk("reset_uo_out", uo_out, 8'h00);
        chk("reset_uio_out", uio_out, 8'h00);
        chk("reset_uio_oe", uio_oe, 8'h00);
        #4 rst_n = 1'b1;
        tick();
        chk("idle_after_reset", uo_out, 8'h00);

        mode = 1'b1;
        foreach (vecs[i]) begin
            req = vecs[i].req;
            op  = vecs[i].op;
            uio = vecs[i].uio;
            tick();
            chk("vec_eval", uo_out, {exp_cnt, 2'b00, vecs[i].grant});
            tick();
            chk("vec_hold", uo_out, {exp_cnt, 1'b1, vecs[i].res, vecs[i].grant});
            op  = ~op;
            uio = ~uio;
            tick();
            chk("vec_hold_stable", uo_out, {exp_cnt, 1'b1, vecs[i].res, vecs[i].grant});
            req = '0;
            tick();
            exp_cnt++;
            chk("vec_ack", uo_out, {exp_cnt, 6'b0});
        end

        clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_cnt = '0;
        chk("clear_idle", uo_out, 8'h00);

        // round-robin, all requesting, each winner acks by dropping its bit
        mode = 1'b0;
        op   = 2'b00;
        uio  = 8'h00;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] g;
            g = 4'b0001 << (k % 4);
            req = 4'hF;
            tick();
            chk("rr_grant", uo_out, {exp_cnt, 2'b00, g});
            tick();
            chk("rr_hold", uo_out, {exp_cnt, 2'b10, g});
            req = 4'hF & ~g;
            tick();
            exp_cnt++;
            chk("rr_ack", uo_out, {exp_cnt, 6'b0});
        end

        // fixed priority: requester 3 starves while requester 1 keeps asking
        mode = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req = 4'b1010;
            tick();
            chk("fixed_grant", uo_out, {exp_cnt, 2'b00, 4'b0010});
            tick();
            chk("fixed_hold", uo_out, {exp_cnt, 2'b10, 4'b0010});
            req = 4'b1000;
            tick();
            exp_cnt++;
            chk("fixed_ack", uo_out, {exp_cnt, 6'b0});
        end

        // timeout with req held: three HOLD cycles, count unchanged, pointer advanced
        req = '0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_cnt = '0;
        mode = 1'b0;
        op   = 2'b00;
        uio  = 8'b0000_0001;
        req  = 4'b0001;
        tick();
        chk("to_eval", uo_out, {exp_cnt, 2'b00, 4'b0001});
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("to_hold", uo_out, {exp_cnt, 2'b11, 4'b0001});
        end
        tick();
        chk("to_exit", uo_out, {exp_cnt, 6'b0});
        req = 4'b0011;
        tick();
        chk("to_ptr_adv", uo_out, {exp_cnt, 2'b00, 4'b0010});

        // ack on the same edge the timeout would fire counts as an ack
        tick();
        chk("ackto_hold", uo_out, {exp_cnt, 2'b10, 4'b0010});
        tick();
        tick();
        req = 4'b0001;
        tick();
        exp_cnt++;
        chk("ackto_exit", uo_out, {exp_cnt, 6'b0});

        // req dropped during EVAL: transaction completes, exits on first HOLD cycle
        tick();
        chk("evdrop_eval", uo_out, {exp_cnt, 2'b00, 4'b0001});
        req = '0;
        tick();
        chk("evdrop_hold", uo_out, {exp_cnt, 2'b11, 4'b0001});
        tick();
        exp_cnt++;
        chk("evdrop_exit", uo_out, {exp_cnt, 6'b0});

        // ena dropped mid-HOLD aborts without counting
        op  = 2'b01;
        uio = 8'b0011_0000;
        req = 4'b0100;
        tick();
        chk("ena_eval", uo_out, {exp_cnt, 2'b00, 4'b0100});
        tick();
        chk("ena_hold", uo_out, {exp_cnt, 2'b11, 4'b0100});
        ena = 1'b0;
        tick();
        chk("ena_abort", uo_out, {exp_cnt, 6'b0});
        req = '0;
        ena = 1'b1;
        tick();
        chk("ena_idle", uo_out, {exp_cnt, 6'b0});

        // clear mid-HOLD zeroes the count but HOLD carries on
        req = 4'b0100;
        tick();
        chk("clr_eval", uo_out, {exp_cnt, 2'b00, 4'b0100});
        tick();
        chk("clr_hold", uo_out, {exp_cnt, 2'b11, 4'b0100});
        clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_cnt = '0;
        chk("clr_mid_hold", uo_out, {exp_cnt, 2'b11, 4'b0100});
        tick();
        chk("clr_hold_cont", uo_out, {exp_cnt, 2'b11, 4'b0100});
        req = '0;
        tick();
        exp_cnt++;
        chk("clr_ack", uo_out, {exp_cnt, 6'b0});

        // asynchronous reset mid-HOLD
        op  = 2'b00;
        uio = 8'b0000_0100;
        req = 4'b0010;
        tick();
        tick();
        chk("rst_hold", uo_out, {exp_cnt, 2'b11, 4'b0010});
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async", uo_out, 8'h00);
        req = '0;
        #2 rst_n = 1'b1;
        exp_cnt = '0;
        uio = 8'b0000_0001;
        req = 4'b0001;
        tick();
        chk("rst_first_arb", uo_out, {exp_cnt, 2'b00, 4'b0001});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tt_um_logic_arbiter.md
TT_UM_LOGIC_ARBITER -- requirements
Module: tt_um_logic_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15, meaning: maximum HOLD cycles before forced release; range 1..15.
REQ-002 clk  input  1  system clock; one clock domain, all flops rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ena  input  1  tile enable; low holds block idle.
REQ-005 ui_in  input  8  [3:0] req per requester; [5:4] op select; [6] mode (0 round-robin, 1 fixed priority); [7] clear.
REQ-006 uio_in  input  8  operands; requester i drives a on bit 2i and b on bit 2i+1.
REQ-007 uo_out  output  8  [3:0] one-hot grant; [4] result; [5] valid; [7:6] completed-transaction count mod 4.
REQ-008 uio_out  output  8  constant 0.
REQ-009 uio_oe  output  8  constant 0 (all bidirectional pins are inputs).

Function
REQ-010 The block SHALL share one 2-input logic unit among 4 requesters: op 00 XOR, 01 AND, 10 OR, 11 XNOR.
REQ-011 The FSM SHALL have states IDLE, EVAL, HOLD.
REQ-012 In IDLE with ena=1 and any req bit set, the arbiter SHALL pick the winner and go to EVAL at the next edge, registering grant, op and the winner's two operand bits.
REQ-013 Round-robin mode SHALL search from the pointer upward, wrapping 3->0; fixed mode SHALL pick the lowest set index.
REQ-014 EVAL SHALL last exactly 1 cycle and register the result, then enter HOLD with valid=1.
REQ-015 Latency: req sampled at edge N -> grant visible after N, valid and result visible after N+1.
REQ-016 In HOLD, grant, result and valid SHALL stay stable; operand or op changes SHALL be ignored.
REQ-017 HOLD SHALL exit to IDLE when req[winner]=0 (ack): count increments by 1 mod 4, pointer = winner+1 mod 4.
REQ-018 HOLD SHALL exit to IDLE after TIMEOUT cycles without ack: count unchanged, pointer = winner+1 mod 4.
REQ-019 If ack and timeout occur in the same cycle, the exit SHALL be treated as an ack.
REQ-020 In IDLE, grant, valid and result SHALL be 0; there is at least one IDLE cycle between grants.
REQ-021 If a requester's req drops during EVAL, the transaction SHALL complete; HOLD exits on its first cycle as an ack.
REQ-022 ena=0 in any state SHALL force IDLE at the next edge and clear grant, valid and result; count and pointer are held; aborted transactions are not counted.
REQ-023 Clear=1 SHALL zero count and pointer at the next edge in any state without disturbing the FSM; clear wins over a simultaneous increment.

Reset
REQ-024 On rst_n=0, state SHALL be IDLE and grant, result, valid, count, pointer and the timeout counter SHALL all be 0, asynchronously.
REQ-025 Reset release SHALL be synchronous to clk; the first arbitration happens at the first edge after release.

Structure
REQ-026 Shared package tt_logic_pkg SHALL hold the op encodings, the state enum, NUM_REQ=4 and the timeout counter width (4).
REQ-027 One sub-module rr_arbiter_4 SHALL be used: 4-bit req, 2-bit pointer and mode in; one-hot grant and 2-bit index out; purely combinational.
REQ-028 The FSM, operand latch, logic unit and counters SHALL live in the top module.

Verification
REQ-029 Reset then req=0001, op=00, a=1, b=0 -> grant=0001 after 1 edge, valid=1 and result=1 after 2 edges; drop req -> IDLE, count=1.
REQ-030 Round-robin with req=1111 held and ack by toggling each winner -> grant order 0001, 0010, 0100, 1000, 0001; count wraps 3->0.
REQ-031 Fixed mode with req=1010 -> grant 0010 repeatedly; requester 3 is never served while requester 1 keeps re-requesting.
REQ-032 TIMEOUT=3 and req held high -> valid stays high 3 cycles, then IDLE; count unchanged, pointer advanced.
REQ-033 ena dropped in HOLD -> next edge: uo_out[5:0]=0 and count unchanged; clear=1 mid-HOLD -> count=0 and HOLD continues.
REQ-034 rst_n asserted mid-HOLD -> all outputs 0 immediately, without waiting for a clock edge.
